// File: rtl/gate_chk_pkg.sv
// Shared definitions for the two-input gate vector checker.
//   state_e   : checker FSM states
//   TT_*      : expected truth tables, bit i = expected y for {a,b} = i
//   ERR_MAX   : highest error count a four-vector sweep can produce
//   tt_bit()  : expected output for one vector index
package gate_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_XNOR = 4'b1001;

   localparam logic [2:0] ERR_MAX = 3'd4;

   function automatic logic tt_bit(input logic [3:0] tt, input logic [1:0] idx);
      return tt[idx];
   endfunction

endpackage

// File: rtl/gate_vector_checker.sv
// Clocked stimulus/response checker for a two-input gate.
// Walks {a,b} through 00,01,10,11, holds each vector SETTLE cycles, samples
// dut_y on the following cycle and compares it with EXP_TT.
//   clk, rst_n       : clock, synchronous active-low reset
//   start            : level request for one sweep (accepted in IDLE only)
//   dut_y            : gate output under test
//   vec_a, vec_b     : gate inputs
//   busy, done       : sweep in progress / one-cycle completion pulse
//   pass, err_count  : sweep verdict and number of mismatching vectors
//   fail_valid, fail_idx : first mismatching vector of the sweep
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | vectors at 00, waiting for start
// ST_SETTLE  | current vector held, cnt counting down to 0
// ST_SAMPLE  | compare dut_y with EXP_TT[idx], advance or finish
// ST_DONE    | done pulse cycle, vectors return to 00
module gate_vector_checker
   import gate_chk_pkg::*;
#(
   parameter logic [3:0] EXP_TT = TT_NOR,
   parameter int         SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       dut_y,
   output logic       vec_a,
   output logic       vec_b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic       fail_valid,
   output logic [1:0] fail_idx
);

   localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

   state_e     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic [1:0] vec_q, vec_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   logic [2:0] err_count_q, err_count_d;
   logic       fail_valid_q, fail_valid_d;
   logic [1:0] fail_idx_q, fail_idx_d;

   logic       mismatch;
   logic       last_vec;

   assign mismatch = (dut_y != tt_bit(EXP_TT, idx_q));
   assign last_vec = (idx_q == 2'd3);

   // state register (all registers, synchronous reset)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         idx_q        <= 2'd0;
         cnt_q        <= 4'd0;
         vec_q        <= 2'b00;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_count_q  <= 3'd0;
         fail_valid_q <= 1'b0;
         fail_idx_q   <= 2'd0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         vec_q        <= vec_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         err_count_q  <= err_count_d;
         fail_valid_q <= fail_valid_d;
         fail_idx_q   <= fail_idx_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_SETTLE;
         ST_SETTLE: if (cnt_q == 4'd0) state_d = ST_SAMPLE;
         ST_SAMPLE: state_d = last_vec ? ST_DONE : ST_SETTLE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // datapath / registered-output logic
   always_comb begin
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      vec_d        = vec_q;
      busy_d       = busy_q;
      done_d       = done_q;
      pass_d       = pass_q;
      err_count_d  = err_count_q;
      fail_valid_d = fail_valid_q;
      fail_idx_d   = fail_idx_q;

      case (state_q)
         ST_IDLE: begin
            vec_d  = 2'b00;
            busy_d = 1'b0;
            done_d = 1'b0;
            if (start) begin
               idx_d        = 2'd0;
               cnt_d        = CNT_INIT;
               err_count_d  = 3'd0;
               fail_valid_d = 1'b0;
               fail_idx_d   = 2'd0;
               pass_d       = 1'b0;
               busy_d       = 1'b1;
            end
         end

         ST_SETTLE: begin
            if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
         end

         ST_SAMPLE: begin
            if (mismatch) begin
               // four vectors cannot exceed ERR_MAX; the guard keeps it from wrapping regardless
               if (err_count_q != ERR_MAX) err_count_d = err_count_q + 3'd1;
               if (!fail_valid_q) begin
                  fail_idx_d   = idx_q;
                  fail_valid_d = 1'b1;
               end
            end
            if (last_vec) begin
               busy_d = 1'b0;
               done_d = 1'b1;
               // verdict uses the count including this final sample
               pass_d = (err_count_d == 3'd0);
            end else begin
               idx_d = idx_q + 2'd1;
               vec_d = idx_q + 2'd1;
               cnt_d = CNT_INIT;
            end
         end

         ST_DONE: begin
            done_d = 1'b0;
            vec_d  = 2'b00;
         end

         default: begin
            vec_d  = 2'b00;
            busy_d = 1'b0;
            done_d = 1'b0;
         end
      endcase
   end

   assign vec_a      = vec_q[1];
   assign vec_b      = vec_q[0];
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_count_q;
   assign fail_valid = fail_valid_q;
   assign fail_idx   = fail_idx_q;

endmodule
